result_byte_streamer: RTL and testbench

Downstream output stage for the processor's 32-bit `result`. It captures result words into a small word FIFO and streams each word out as four bytes over an 8-bit valid/ready port, with a last-byte marker. It replaces the top level's direct `out <= result[7:0]` truncation, so all 32 bits reach the pins without losing words that arrive in bursts.

---
 rtl/result_byte_streamer_if.sv | 28 ++
 rtl/result_byte_streamer.sv | 147 ++++++++++++++
 tb/tb_result_byte_streamer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/result_byte_streamer_if.sv
// Interface bundling the result capture side and the byte output side of result_byte_streamer.
// Latency: none (wires only).
// Backpressure: out_ready throttles the byte stream; result_ready reflects FIFO space.
//   slave  : the streamer itself (drives result_ready, out*, count, overflow)
//   master : the producer/consumer environment (drives result, result_valid, out_ready)
interface result_byte_streamer_if #(
  parameter int DEPTH = 4
);
  logic [31:0]            result;
  logic                   result_valid;
  logic                   result_ready;
  logic [7:0]             out;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  modport slave (
    input  result, result_valid, out_ready,
    output result_ready, out, out_valid, out_last, count, overflow
  );

  modport master (
    output result, result_valid, out_ready,
    input  result_ready, out, out_valid, out_last, count, overflow
  );
endinterface

// File: rtl/result_byte_streamer.sv
// Captures 32-bit result words into a word FIFO and streams each as 4 bytes with a last marker.
// Latency: push at edge N -> byte 0 valid after edge N+1; one byte/cycle, no bubble between words.
// Backpressure: out_ready low holds out/out_last; a full FIFO drops result_ready (strobe mode) or
//   sets sticky overflow (change mode).
// Ports: clk, rst (sync, active high); bus.result/result_valid/result_ready capture side;
//   bus.out/out_valid/out_ready/out_last byte side; bus.count words queued; bus.overflow sticky.
module result_byte_streamer #(
  parameter int DEPTH             = 4,
  parameter int LSB_FIRST         = 1,
  parameter int CAPTURE_ON_CHANGE = 0
) (
  input logic                  clk,
  input logic                  rst,
  result_byte_streamer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   prev_q;
  logic          overflow_q, overflow_d;

  state_t        state_q, state_d;
  logic [31:0]   word_q, word_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  logic          full;
  logic          push_req;
  logic          push;
  logic          pop;
  logic [31:0]   head;

  // Byte i of a word in transmit order.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    logic [1:0] k;
    k = (LSB_FIRST != 0) ? i : (2'd3 - i);
    return w[{k, 3'b000} +: 8];
  endfunction

  // Full is taken from the registered count, so a pop in the same cycle cannot free a slot.
  assign full     = (count_q == CW'(DEPTH));
  assign push_req = (CAPTURE_ON_CHANGE != 0) ? (bus.result != prev_q) : bus.result_valid;
  assign push     = push_req && !full;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    pop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          word_d      = head;
          idx_d       = 2'd0;
          out_d       = byte_of(head, 2'd0);
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (out_valid_q && bus.out_ready) begin
          if (idx_q != 2'd3) begin
            idx_d      = idx_q + 2'd1;
            out_d      = byte_of(word_q, idx_q + 2'd1);
            out_last_d = (idx_q == 2'd2);
          end else if (count_q != '0) begin
            // Chain straight into the next word so the stream has no bubble.
            pop         = 1'b1;
            word_d      = head;
            idx_d       = 2'd0;
            out_d       = byte_of(head, 2'd0);
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  assign overflow_d = overflow_q || ((CAPTURE_ON_CHANGE != 0) && push_req && full);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      prev_q      <= '0;
      overflow_q  <= 1'b0;
      state_q     <= IDLE;
      word_q      <= '0;
      idx_q       <= 2'd0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      prev_q      <= bus.result;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.result_ready = !full;
  assign bus.out          = out_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_last     = out_last_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_result_byte_streamer.sv
// Bench for result_byte_streamer: strobe-mode instance (u0) and change-mode instance (u1).
// Expected bytes are queued when words are driven and compared as the DUT transfers them.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_result_byte_streamer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_byte_streamer_if #(.DEPTH(4)) bus0 ();
  result_byte_streamer_if #(.DEPTH(4)) bus1 ();

  result_byte_streamer #(.DEPTH(4), .LSB_FIRST(1), .CAPTURE_ON_CHANGE(0)) u0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  result_byte_streamer #(.DEPTH(4), .LSB_FIRST(1), .CAPTURE_ON_CHANGE(1)) u1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int passes = 0;
  int total  = 0;
  logic [8:0] q0[$];  // {last, byte} expected from u0
  logic [8:0] q1[$];  // {last, byte} expected from u1
  bit   track_max = 1'b0;
  int   max0 = 0;
  bit   wr_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic exp_word(input int which, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [8:0] e;
      e = {(i == 3), w[8*i +: 8]};
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int which, input string tag);
    for (int c = 0; c < 100; c++) begin
      if (((which == 0) ? q0.size() : q1.size()) == 0) break;
      tick();
    end
    chk(tag, (which == 0) ? q0.size() : q1.size(), 0);
  endtask

  // Scoreboard monitor: a transfer happens at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (track_max && (int'(bus0.count) > max0)) max0 = int'(bus0.count);
      if (bus0.out_valid && bus0.out_ready) begin
        if (q0.size() == 0) chk("u0_unexpected_byte", {bus0.out_last, bus0.out}, 9'h1ff);
        else                chk("u0_byte", {bus0.out_last, bus0.out}, q0.pop_front());
      end
      if (bus1.out_valid && bus1.out_ready) begin
        if (q1.size() == 0) chk("u1_unexpected_byte", {bus1.out_last, bus1.out}, 9'h1ff);
        else                chk("u1_byte", {bus1.out_last, bus1.out}, q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    bus0.result = '0; bus0.result_valid = 1'b0; bus0.out_ready = 1'b1;
    bus1.result = '0; bus1.result_valid = 1'b0; bus1.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_out",          bus0.out, 0);
    chk("rst_out_valid",    bus0.out_valid, 0);
    chk("rst_out_last",     bus0.out_last, 0);
    chk("rst_count",        bus0.count, 0);
    chk("rst_overflow",     bus0.overflow, 0);
    chk("rst_result_ready", bus0.result_ready, 1);
    chk("rst_u1_out_valid", bus1.out_valid, 0);

    // Single word, capture latency and byte sequence
    w = 32'h11223344;
    bus0.result = w; bus0.result_valid = 1'b1; exp_word(0, w);
    tick();
    bus0.result_valid = 1'b0;
    chk("single_count_after_push", bus0.count, 1);
    chk("single_not_yet_valid",    bus0.out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("single_valid", bus0.out_valid, 1);
      chk("single_byte",  bus0.out, (w >> (8*i)) & 32'hff);
      chk("single_last",  bus0.out_last, (i == 3) ? 1 : 0);
      if (i == 0) chk("single_count_after_pop", bus0.count, 0);
    end
    tick();
    chk("single_idle", bus0.out_valid, 0);

    // Backpressure: byte 0 held for 5 cycles
    bus0.out_ready = 1'b0;
    bus0.result = w; bus0.result_valid = 1'b1; exp_word(0, w);
    tick();
    bus0.result_valid = 1'b0;
    tick();
    for (int j = 0; j < 5; j++) begin
      chk("bp_hold_byte",  bus0.out, 32'h44);
      chk("bp_hold_valid", bus0.out_valid, 1);
      tick();
    end
    bus0.out_ready = 1'b1;
    drain(0, "bp_drain");
    tick();

    // Fill and full
    bus0.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      w = 32'hA0B0C000 + k * 32'h01010101;
      bus0.result = w; bus0.result_valid = 1'b1;
      if (k < 5) exp_word(0, w);
      tick();
      if (k == 4) begin
        chk("fill_peak_count",   bus0.count, 4);
        chk("fill_ready_low",    bus0.result_ready, 0);
      end
      if (k == 5) chk("fill_6th_refused", bus0.count, 4);
    end
    bus0.result_valid = 1'b0;
    bus0.out_ready = 1'b1;
    for (int b = 0; b < 20; b++) begin
      @(negedge clk);
      chk("fill_back_to_back", bus0.out_valid, 1);
    end
    @(negedge clk);
    chk("fill_all_drained", q0.size(), 0);
    chk("fill_idle_after",  bus0.out_valid, 0);
    tick();

    // Wrap-around with out_ready toggling
    max0 = 0; track_max = 1'b1; wr_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          bit ok;
          w = 32'h5A000000 + k * 32'h00030507;
          exp_word(0, w);
          bus0.result = w; bus0.result_valid = 1'b1;
          ok = 1'b0;
          for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = bus0.result_ready;
            @(posedge clk);
            #1;
          end
          if (!ok) chk("wrap_push_timeout", 0, 1);
        end
        bus0.result_valid = 1'b0;
        wr_done = 1'b1;
      end
      begin
        for (int c = 0; c < 400; c++) begin
          @(posedge clk);
          #1;
          bus0.out_ready = !bus0.out_ready;
          if (wr_done && q0.size() == 0) break;
        end
      end
    join
    bus0.out_ready = 1'b1;
    track_max = 1'b0;
    chk("wrap_all_bytes", q0.size(), 0);
    chk("wrap_count_le_depth", (max0 <= 4) ? 1 : 0, 1);
    repeat (3) tick();

    // Change mode: 0,0,5,5,5,9,9
    exp_word(1, 32'h5);
    exp_word(1, 32'h9);
    bus1.result = 32'h0; tick();
    bus1.result = 32'h0; tick();
    repeat (3) begin bus1.result = 32'h5; tick(); end
    repeat (2) begin bus1.result = 32'h9; tick(); end
    drain(1, "chg_two_words");
    repeat (4) tick();
    chk("chg_no_extra", q1.size(), 0);
    chk("chg_overflow_clear", bus1.overflow, 0);

    // Change mode overflow: 7 distinct values with sink stalled
    bus1.out_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      w = 32'h100 + k;
      if (k <= 5) exp_word(1, w);
      bus1.result = w;
      tick();
    end
    chk("ovf_set", bus1.overflow, 1);
    bus1.out_ready = 1'b1;
    drain(1, "ovf_drain");
    repeat (3) tick();
    chk("ovf_sticky", bus1.overflow, 1);
    rst = 1'b1;
    bus1.result = 32'h0;
    tick();
    rst = 1'b0;
    chk("ovf_cleared_by_rst", bus1.overflow, 0);
    tick();

    // Reset mid-word with two words queued
    w = 32'hDEADBEEF;
    q0.push_back({1'b0, w[7:0]});
    q0.push_back({1'b0, w[15:8]});
    bus0.result = w;            bus0.result_valid = 1'b1; tick();
    bus0.result = 32'hCAFEF00D; tick();
    bus0.result = 32'h0BADC0DE; tick();
    bus0.result_valid = 1'b0;
    tick();
    chk("mid_bytes_sent", q0.size(), 0);
    chk("mid_queued",     bus0.count, 2);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", bus0.out_valid, 0);
    chk("mid_rst_count", bus0.count, 0);
    rst = 1'b0;
    repeat (10) tick();
    chk("mid_no_stale", bus0.out_valid, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
